spartan_arbiter: RTL and testbench

Packet-locked round-robin arbiter that shares one downstream Spartan master port among NUM_MASTERS upstream Spartan masters. It routes each in-order response packet back to the master that issued the matching request. It sits in front of a width adapter or a single slave, e.g. ahead of the downsizer on the half-width link.

---
 rtl/spartan_pkg.sv | 20 ++
 rtl/spartan_id_fifo.sv | 54 +++++
 rtl/spartan_arbiter.sv | 134 +++++++++++++
 tb/tb_spartan_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spartan_pkg.sv
// spartan_pkg
//   Constants and helpers shared by the Spartan bus blocks (arbiter,
//   downsizer, upsizer).
//   - ST_IDLE / ST_LOCKED : arbiter FSM encodings
//   - idWidth(n)          : width of a master ID, max(1, clog2(n))
//   - lastBit(bwidth)     : index of the LAST flag in a bus word
package spartan_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic int unsigned idWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned lastBit(input int unsigned bwidth);
        return bwidth + 1;
    endfunction

endpackage

// File: rtl/spartan_id_fifo.sv
// spartan_id_fifo
//   Synchronous FIFO of master IDs, one entry per request packet still
//   waiting for its response.
//   CLK, RST : clock, synchronous active-high reset (empties the FIFO)
//   push     : write pushId
//   pushId   : ID to store
//   pop      : drop the head entry
//   full     : DEPTH entries held
//   empty    : no entries held
//   head     : oldest entry (valid when !empty)
module spartan_id_fifo #(
    parameter int unsigned ID_W  = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            push,
    input  logic [ID_W-1:0] pushId,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [ID_W-1:0] mem [DEPTH];
    logic [AW:0]     wrPtr;
    logic [AW:0]     rdPtr;
    logic            pushOk;
    logic            popOk;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head   = mem[rdPtr[AW-1:0]];
    assign popOk  = pop && !empty;
    // A push while full is accepted when the head leaves on the same edge.
    assign pushOk = push && (!full || popOk);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (pushOk) mem[wrPtr[AW-1:0]] <= pushId;
    end

endmodule

// File: rtl/spartan_arbiter.sv
// spartan_arbiter
//   Packet-locked round-robin arbiter sharing one downstream Spartan port
//   among NUM_MASTERS masters; in-order responses are steered back to the
//   master that issued the matching request.
//   CLK, RST    : clock, synchronous active-high reset
//   SpMBUS_IN   : request words, master i at [i*(BWIDTH+2) +: BWIDTH+2]
//   SpMVLD_IN   : request valid per master
//   SpMRDY_IN   : request ready per master
//   SpMBUS_OUT  : request word to slave
//   SpMVLD_OUT  : request valid to slave
//   SpMRDY_OUT  : slave ready
//   SpSBUS_IN   : response word from slave
//   SpSVLD_IN   : response valid
//   SpSRDY_IN   : response ready to slave
//   SpSBUS_OUT  : response word, broadcast to all masters
//   SpSVLD_OUT  : response valid, one-hot to owning master
//   SpSRDY_OUT  : response ready per master
module spartan_arbiter
    import spartan_pkg::*;
#(
    parameter int unsigned BWIDTH      = 64,
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_MASTERS*(BWIDTH+2)-1:0] SpMBUS_IN,
    input  logic [NUM_MASTERS-1:0]          SpMVLD_IN,
    output logic [NUM_MASTERS-1:0]          SpMRDY_IN,
    output logic [BWIDTH+1:0]               SpMBUS_OUT,
    output logic                            SpMVLD_OUT,
    input  logic                            SpMRDY_OUT,
    input  logic [BWIDTH+1:0]               SpSBUS_IN,
    input  logic                            SpSVLD_IN,
    output logic                            SpSRDY_IN,
    output logic [BWIDTH+1:0]               SpSBUS_OUT,
    output logic [NUM_MASTERS-1:0]          SpSVLD_OUT,
    input  logic [NUM_MASTERS-1:0]          SpSRDY_OUT
);
    localparam int unsigned WW   = BWIDTH + 2;
    localparam int unsigned LAST = lastBit(BWIDTH);
    localparam int unsigned ID_W = idWidth(NUM_MASTERS);

    logic [0:0]      state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] rrPtr;
    logic [ID_W-1:0] nextPtr;
    logic [ID_W-1:0] selId;
    logic [ID_W-1:0] cand;
    logic            selFound;
    logic [WW-1:0]   mBus [NUM_MASTERS];
    logic [WW-1:0]   grantBus;
    logic            grantVld;
    logic            locked;
    logic            reqLastXfer;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            fifoPop;
    logic [ID_W-1:0] fifoHead;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_split
        assign mBus[g] = SpMBUS_IN[g*WW +: WW];
    end

    // First requester at or above rrPtr, wrapping around.
    always_comb begin
        selId    = '0;
        selFound = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = ID_W'((32'(rrPtr) + i) % NUM_MASTERS);
            if (!selFound && SpMVLD_IN[cand]) begin
                selFound = 1'b1;
                selId    = cand;
            end
        end
    end

    assign locked      = (state == ST_LOCKED);
    assign grantBus    = mBus[grant];
    assign grantVld    = SpMVLD_IN[grant];
    assign reqLastXfer = locked && grantVld && SpMRDY_OUT && grantBus[LAST];
    assign nextPtr     = (grant == ID_W'(NUM_MASTERS - 1)) ? '0 : grant + ID_W'(1);

    assign SpMVLD_OUT  = locked && grantVld;
    assign SpMBUS_OUT  = locked ? grantBus : '0;

    always_comb begin
        SpMRDY_IN = '0;
        if (locked) SpMRDY_IN[grant] = SpMRDY_OUT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            grant <= '0;
            rrPtr <= '0;
        end else if (state == ST_IDLE) begin
            // Full is checked only here, so a locked packet always has a slot.
            if (selFound && !fifoFull) begin
                grant <= selId;
                state <= ST_LOCKED;
            end
        end else if (reqLastXfer) begin
            rrPtr <= nextPtr;
            state <= ST_IDLE;
        end
    end

    // Response steering: head of the ID FIFO owns the response channel.
    assign SpSBUS_OUT = SpSBUS_IN;
    assign SpSRDY_IN  = !fifoEmpty && SpSRDY_OUT[fifoHead];
    assign fifoPop    = SpSVLD_IN && SpSRDY_IN && SpSBUS_IN[LAST];

    always_comb begin
        SpSVLD_OUT = '0;
        if (!fifoEmpty) SpSVLD_OUT[fifoHead] = SpSVLD_IN;
    end

    spartan_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_idFifo (
        .CLK    (CLK),
        .RST    (RST),
        .push   (reqLastXfer),
        .pushId (grant),
        .pop    (fifoPop),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .head   (fifoHead)
    );

endmodule

// File: tb/tb_spartan_arbiter.sv
// tb_spartan_arbiter
//   Directed bench for spartan_arbiter with BWIDTH=8, NUM_MASTERS=2,
//   FIFO_DEPTH=4. Word layout: bit 9 LAST, bit 8 zero, bits 7:0 payload.
module tb_spartan_arbiter;

    localparam int unsigned BW = 8;
    localparam int unsigned WW = BW + 2;

    logic          CLK;
    logic          RST;
    logic [WW-1:0] bus0;
    logic [WW-1:0] bus1;
    logic [2*WW-1:0] mBusIn;
    logic [1:0]    mVldIn;
    logic [1:0]    mRdyIn;
    logic [WW-1:0] mBusOut;
    logic          mVldOut;
    logic          mRdyOut;
    logic [WW-1:0] sBusIn;
    logic          sVldIn;
    logic          sRdyIn;
    logic [WW-1:0] sBusOut;
    logic [1:0]    sVldOut;
    logic [1:0]    sRdyOut;

    assign mBusIn = {bus1, bus0};

    spartan_arbiter #(
        .BWIDTH      (BW),
        .NUM_MASTERS (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SpMBUS_IN  (mBusIn),
        .SpMVLD_IN  (mVldIn),
        .SpMRDY_IN  (mRdyIn),
        .SpMBUS_OUT (mBusOut),
        .SpMVLD_OUT (mVldOut),
        .SpMRDY_OUT (mRdyOut),
        .SpSBUS_IN  (sBusIn),
        .SpSVLD_IN  (sVldIn),
        .SpSRDY_IN  (sRdyIn),
        .SpSBUS_OUT (sBusOut),
        .SpSVLD_OUT (sVldOut),
        .SpSRDY_OUT (sRdyOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk(input logic last, input logic [7:0] d);
        return {last, 1'b0, d};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Simple two-master model: each master sends 2-beat packets whose
    // payload is {master, beat}; counters advance on accepted beats.
    logic [1:0]  reqEn;
    logic        cnt0;
    logic        cnt1;
    logic [1:0]  xferMask;
    logic        obsVld;
    logic [7:0]  xferLog [$];

    task automatic drive();
        bus0   = mk(cnt0, {7'h00, cnt0});
        bus1   = mk(cnt1, {7'h08, cnt1});
        mVldIn = reqEn | {cnt1, cnt0};
        #1;
        obsVld   = mVldOut;
        xferMask = mRdyIn & mVldIn;
        if (mVldOut && mRdyOut) xferLog.push_back(mBusOut[7:0]);
    endtask

    task automatic adv();
        tick();
        if (xferMask[0]) cnt0 = ~cnt0;
        if (xferMask[1]) cnt1 = ~cnt1;
    endtask

    task automatic doReset();
        RST    = 1'b1;
        mVldIn = '0;
        sVldIn = 1'b0;
        tick();
        tick();
        RST    = 1'b0;
    endtask

    logic [12:0] expVldPat;
    logic [7:0]  expLog [8];
    logic [1:0]  expDrain [5];

    initial begin
        RST = 1'b1; bus0 = '0; bus1 = '0; mVldIn = '0; mRdyOut = 1'b1;
        sBusIn = '0; sVldIn = 1'b0; sRdyOut = '0;
        reqEn = '0; cnt0 = 1'b0; cnt1 = 1'b0; xferMask = '0; obsVld = 1'b0;

        // Reset state
        doReset();
        #1;
        checkEq("rstMVld", mVldOut, 0);
        checkEq("rstMRdy", mRdyIn, 0);
        checkEq("rstSVld", sVldOut, 0);
        checkEq("rstSRdy", sRdyIn, 0);
        checkEq("rstMBus", mBusOut, 0);
        tick();

        // Response while FIFO empty is stalled
        sVldIn = 1'b1; sBusIn = mk(1, 8'h55); sRdyOut = 2'b11;
        #1;
        checkEq("emptySRdy", sRdyIn, 0);
        checkEq("emptySVld", sVldOut, 0);
        checkEq("sBusPass", sBusOut, mk(1, 8'h55));
        tick();
        #1;
        checkEq("emptySRdy2", sRdyIn, 0);
        sVldIn = 1'b0;
        tick();

        // Single master 0, 3-beat packet, one slave stall
        mVldIn = 2'b01; bus0 = mk(0, 8'hA1);
        #1;
        checkEq("t1Idle", mVldOut, 0);
        tick();
        #1;
        checkEq("t1Vld1", mVldOut, 1);
        checkEq("t1Bus1", mBusOut, mk(0, 8'hA1));
        checkEq("t1Rdy1", mRdyIn, 2'b01);
        tick();
        bus0 = mk(0, 8'hA2); mRdyOut = 1'b0;
        #1;
        checkEq("t1StallRdy", mRdyIn, 2'b00);
        checkEq("t1StallVld", mVldOut, 1);
        tick();
        mRdyOut = 1'b1;
        #1;
        checkEq("t1Rdy2", mRdyIn, 2'b01);
        checkEq("t1Bus2", mBusOut, mk(0, 8'hA2));
        tick();
        bus0 = mk(1, 8'hA3);
        #1;
        checkEq("t1Bus3", mBusOut, mk(1, 8'hA3));
        tick();
        mVldIn = 2'b00;
        #1;
        checkEq("t1PostVld", mVldOut, 0);
        checkEq("t1PostRdy", mRdyIn, 0);
        sVldIn = 1'b1; sBusIn = mk(0, 8'hB1); sRdyOut = 2'b01;
        #1;
        checkEq("t1RspVld1", sVldOut, 2'b01);
        checkEq("t1RspRdy1", sRdyIn, 1);
        tick();
        sBusIn = mk(1, 8'hB2);
        #1;
        checkEq("t1RspVld2", sVldOut, 2'b01);
        tick();
        #1;
        checkEq("t1EmptyVld", sVldOut, 0);
        checkEq("t1EmptyRdy", sRdyIn, 0);
        sVldIn = 1'b0;

        // Two masters, continuous 2-beat packets, FIFO fills after four
        doReset();
        cnt0 = 1'b0; cnt1 = 1'b0; reqEn = 2'b11; xferLog.delete();
        expVldPat = 13'b0_1101_1011_0110; // bit c = expected valid in cycle c
        for (int c = 0; c < 13; c++) begin
            drive();
            checkEq($sformatf("t2Vld%0d", c), obsVld, expVldPat[c]);
            adv();
        end
        for (int c = 0; c < 3; c++) begin
            drive();
            checkEq("t2FullNoGrant", obsVld, 0);
            adv();
        end
        expLog = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h00, 8'h01, 8'h10, 8'h11};
        checkEq("t2LogSize", xferLog.size(), 8);
        for (int i = 0; i < 8; i++)
            checkEq($sformatf("t2Order%0d", i), (i < xferLog.size()) ? xferLog[i] : 8'hFF, expLog[i]);

        // One response pops; grant follows one cycle after the pop
        sVldIn = 1'b1; sBusIn = mk(1, 8'hD0); sRdyOut = 2'b11;
        drive();
        checkEq("t4Head0", sVldOut, 2'b01);
        adv();
        sVldIn = 1'b0;
        drive();
        checkEq("t4NoGrantPop", obsVld, 0);
        adv();
        drive();
        checkEq("t4GrantAfterPop", obsVld, 1);
        checkEq("t4GrantBus", mBusOut, mk(0, 8'h00));
        reqEn = 2'b00;
        adv();
        drive();
        checkEq("t4LastVld", obsVld, 1);
        adv();
        drive();
        checkEq("t4Idle", obsVld, 0);
        // FIFO now holds 1,0,1,0; head 1 not ready stalls the slave
        sVldIn = 1'b1; sBusIn = mk(1, 8'hD1); sRdyOut = 2'b01;
        #1;
        checkEq("t4BpRdy", sRdyIn, 0);
        checkEq("t4BpVld", sVldOut, 2'b10);
        tick();
        sRdyOut = 2'b11;
        expDrain = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        for (int k = 0; k < 5; k++) begin
            #1;
            checkEq($sformatf("t4Drain%0d", k), sVldOut, expDrain[k]);
            tick();
        end
        sVldIn = 1'b0;

        // Master 1 drops valid mid-packet; grant holds (pointer is 1 here)
        mVldIn = 2'b11; bus1 = mk(0, 8'h21); bus0 = mk(0, 8'h01);
        #1;
        checkEq("t3Idle", mVldOut, 0);
        tick();
        #1;
        checkEq("t3Grant", mRdyIn, 2'b10);
        checkEq("t3Bus", mBusOut, mk(0, 8'h21));
        tick();
        for (int k = 0; k < 3; k++) begin
            mVldIn = 2'b01;
            #1;
            checkEq("t3GapRdy", mRdyIn, 2'b10);
            checkEq("t3GapVld", mVldOut, 0);
            tick();
        end
        mVldIn = 2'b11; bus1 = mk(1, 8'h22);
        #1;
        checkEq("t3LastVld", mVldOut, 1);
        checkEq("t3LastBus", mBusOut, mk(1, 8'h22));
        tick();
        mVldIn = 2'b01; bus0 = mk(1, 8'h02);
        #1;
        checkEq("t3Bubble", mVldOut, 0);
        tick();
        // Push of 0 and pop of 1 on the same edge
        sVldIn = 1'b1; sBusIn = mk(1, 8'hC1); sRdyOut = 2'b11;
        #1;
        checkEq("t3M0Rdy", mRdyIn, 2'b01);
        checkEq("t3RspHead", sVldOut, 2'b10);
        tick();
        mVldIn = 2'b00;
        #1;
        checkEq("t3PushPop", sVldOut, 2'b01);
        checkEq("t3PushPopRdy", sRdyIn, 1);
        tick();
        #1;
        checkEq("t3Empty", sVldOut, 0);
        sVldIn = 1'b0;
        tick();

        // Reset mid-packet with an outstanding ID
        mVldIn = 2'b01; bus0 = mk(1, 8'h03);
        tick();
        #1;
        checkEq("t6Pre", mRdyIn, 2'b01);
        tick();
        mVldIn = 2'b11; bus0 = mk(0, 8'h04); bus1 = mk(0, 8'h24);
        sVldIn = 1'b1; sRdyOut = 2'b00; sBusIn = mk(1, 8'hE0);
        #1;
        checkEq("t6Head", sVldOut, 2'b01);
        tick();
        #1;
        checkEq("t6G1", mRdyIn, 2'b10);
        tick();
        RST = 1'b1;
        #1;
        checkEq("t6MidVld", mVldOut, 1);
        tick();
        sRdyOut = 2'b11;
        #1;
        checkEq("t6RstMVld", mVldOut, 0);
        checkEq("t6RstMRdy", mRdyIn, 0);
        checkEq("t6RstSVld", sVldOut, 0);
        checkEq("t6RstSRdy", sRdyIn, 0);
        checkEq("t6RstMBus", mBusOut, 0);
        RST = 1'b0;
        tick();
        #1;
        checkEq("t6AfterRst", mRdyIn, 2'b01);
        sVldIn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
